// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared op/state encodings and data width for the crossbar master side
package crossbar_pkg;
  localparam int DATA_W = 32;
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_REQ       = 4'b0010,
    ST_READ_WAIT = 4'b0100,
    ST_RESP      = 4'b1000
  } mst_state_e;
endpackage

// File: rtl/master_stats_cnt.sv
// master_stats_cnt: 16-bit saturating event counter; iClk/iRst, inc pulse in, count out
module master_stats_cnt (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge iClk)
    if (iRst) count <= '0;
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/master_port.sv
// master_port: one-outstanding crossbar initiator; cmd_* in, rsp_* out, master_* to slave, stat_* live only with MASTER_STATS_EN
module master_port
  import crossbar_pkg::*;
#(
  parameter int pTimeout = 256
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              master_req,
  output logic              master_cmd,
  output logic [DATA_W-1:0] master_wdata,
  input  logic              master_ack,
  input  logic [DATA_W-1:0] master_rdata,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_to_cnt
);
  localparam int TW = $clog2(pTimeout + 1);
  mst_state_e state, state_nx;
  logic [TW-1:0] to_cnt;
  logic accept, expire;
  assign accept = (state == ST_IDLE) && cmd_valid;
  assign expire = to_cnt == TW'(pTimeout);
  always_comb begin
    cmd_ready  = (state == ST_IDLE) && !iRst;
    master_req = state == ST_REQ;
    rsp_valid  = (state == ST_RESP) && !iRst;
    state_nx   = (state == ST_IDLE)      ? (cmd_valid ? ST_REQ : ST_IDLE) :
                 (state == ST_REQ)       ? (master_ack ? (master_cmd == OP_WRITE ? ST_RESP : ST_READ_WAIT) :
                                            expire ? ST_RESP : ST_REQ) :
                 (state == ST_READ_WAIT) ? ST_RESP : ST_IDLE;
  end
  always_ff @(posedge iClk)
    if (iRst) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge iClk)
    if (iRst) begin
      to_cnt       <= '0;
      master_cmd   <= 1'b0;
      master_wdata <= '0;
      rsp_rdata    <= '0;
      rsp_timeout  <= 1'b0;
    end else begin
      to_cnt      <= accept ? '0 : (state == ST_REQ) ? to_cnt + TW'(1) : to_cnt;
      rsp_rdata   <= (state == ST_READ_WAIT) ? master_rdata : '0;
      rsp_timeout <= (state == ST_REQ) && !master_ack && expire;
      if (accept) begin
        master_cmd   <= cmd_op;
        master_wdata <= cmd_wdata;
      end else if (state == ST_RESP) master_cmd <= 1'b0;
    end
`ifdef MASTER_STATS_EN
  master_stats_cnt u_rd (
    .iClk (iClk),
    .iRst (iRst),
    .inc  (rsp_valid && !rsp_timeout && master_cmd == OP_READ),
    .count(stat_rd_cnt)
  );
  master_stats_cnt u_wr (
    .iClk (iClk),
    .iRst (iRst),
    .inc  (rsp_valid && !rsp_timeout && master_cmd == OP_WRITE),
    .count(stat_wr_cnt)
  );
  master_stats_cnt u_to (
    .iClk (iClk),
    .iRst (iRst),
    .inc  (rsp_valid && rsp_timeout),
    .count(stat_to_cnt)
  );
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
  assign stat_to_cnt = '0;
`endif
endmodule

// File: tb/tb_master_port.sv
// tb_master_port: randomized and directed checks of master_port against a transaction-timeline model
module tb_master_port;
  localparam int PT = 256;
`ifdef MASTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic iClk = 1'b0, iRst = 1'b1;
  always #5 iClk = ~iClk;
  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;
  logic cmd_valid = 0, cmd_op = 0;
  logic [31:0] cmd_wdata = 0;
  logic cmd_ready, rsp_valid, rsp_timeout, master_req, master_cmd, master_ack;
  logic [31:0] rsp_rdata, master_wdata, master_rdata;
  logic [15:0] s_rd, s_wr, s_to;
  logic c8_valid = 0, c8_op = 0, ack8 = 0;
  logic [31:0] c8_wdata = 0, rd8 = 0;
  logic ready8, rsp8_valid, rsp8_timeout, req8, cmd8;
  logic [31:0] rsp8_rdata, wdata8;
  logic [15:0] s8_rd, s8_wr, s8_to;
  master_port #(.pTimeout(PT)) dut (
    .iClk(iClk), .iRst(iRst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .master_req(master_req), .master_cmd(master_cmd), .master_wdata(master_wdata),
    .master_ack(master_ack), .master_rdata(master_rdata),
    .stat_rd_cnt(s_rd), .stat_wr_cnt(s_wr), .stat_to_cnt(s_to)
  );
  master_port #(.pTimeout(8)) dut8 (
    .iClk(iClk), .iRst(iRst), .cmd_valid(c8_valid), .cmd_ready(ready8), .cmd_op(c8_op),
    .cmd_wdata(c8_wdata), .rsp_valid(rsp8_valid), .rsp_rdata(rsp8_rdata), .rsp_timeout(rsp8_timeout),
    .master_req(req8), .master_cmd(cmd8), .master_wdata(wdata8),
    .master_ack(ack8), .master_rdata(rd8),
    .stat_rd_cnt(s8_rd), .stat_wr_cnt(s8_wr), .stat_to_cnt(s8_to)
  );
  logic [31:0] mem = 0;
  int init_cnt = 0;
  bit slave_rand = 0, slave_mute = 0;
  always @(posedge iClk)
    if (iRst) begin
      master_ack <= 1'b0;
      master_rdata <= '0;
      init_cnt <= 0;
    end else begin
      if (init_cnt < 50) init_cnt <= init_cnt + 1;
      master_ack <= master_req && !master_ack && init_cnt >= 50 && !slave_mute &&
                    (!slave_rand || $urandom_range(0, 2) == 0);
      if (master_ack && master_req) begin
        if (master_cmd) mem <= master_wdata;
        master_rdata <= mem;
      end
    end
  int pass_cnt = 0, chk_cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
  endtask
  bit busy = 0, m_op = 0, prev_rst = 0;
  int t_acc = 0, ack_c = -1, n_rd = 0, n_wr = 0, n_to = 0;
  logic [31:0] m_wd = 0, m_mem = 0, m_rd = 0;
  always @(negedge iClk) begin
    int rsp_c;
    bit e_req, e_rsp, e_to;
    if (iRst) begin
      if (prev_rst) begin
        chk("rst_ready", cmd_ready, 0);
        chk("rst_req", master_req, 0);
        chk("rst_cmd", master_cmd, 0);
        chk("rst_wdata", master_wdata, 0);
        chk("rst_rsp", {rsp_valid, rsp_timeout}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_stats", {s_rd, s_wr} | s_to, 0);
      end
      busy = 0;
      m_wd = 0;
      n_rd = 0;
      n_wr = 0;
      n_to = 0;
      prev_rst = 1;
    end else begin
      prev_rst = 0;
      rsp_c = !busy ? -1 : ack_c >= 0 ? ack_c + 1 + int'(!m_op) : t_acc + PT + 2;
      e_req = busy && cyc > t_acc && (ack_c >= 0 ? cyc <= ack_c : cyc <= t_acc + 1 + PT);
      e_rsp = busy && cyc == rsp_c;
      e_to = e_rsp && ack_c < 0;
      chk("cmd_ready", cmd_ready, !busy);
      chk("master_req", master_req, e_req);
      chk("master_cmd", master_cmd, busy && cyc > t_acc && m_op);
      chk("master_wdata", master_wdata, m_wd);
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("rsp_timeout", rsp_timeout, e_to);
      chk("rsp_rdata", rsp_rdata, (e_rsp && !e_to && !m_op) ? m_rd : 32'd0);
      chk("stat_rd", s_rd, STATS ? 32'(n_rd) : 32'd0);
      chk("stat_wr", s_wr, STATS ? 32'(n_wr) : 32'd0);
      chk("stat_to", s_to, STATS ? 32'(n_to) : 32'd0);
      if (e_req && master_ack && ack_c < 0) begin
        ack_c = cyc;
        if (m_op) m_mem = m_wd;
        else m_rd = m_mem;
      end
      if (e_rsp) begin
        busy = 0;
        if (e_to) n_to++;
        else if (m_op) n_wr++;
        else n_rd++;
      end
      if (!busy && cmd_valid && !e_rsp) begin
        busy = 1;
        t_acc = cyc;
        ack_c = -1;
        m_op = cmd_op;
        m_wd = cmd_wdata;
      end
    end
  end
  task automatic send(input bit s, input bit op, input logic [31:0] d, input bit hold, output int c0);
    if (s) begin c8_valid = 1; c8_op = op; c8_wdata = d; end
    else begin cmd_valid = 1; cmd_op = op; cmd_wdata = d; end
    c0 = -1;
    for (int i = 0; i < 400 && c0 < 0; i++) begin
      @(negedge iClk);
      if (s ? ready8 : cmd_ready) c0 = cyc;
      @(posedge iClk);
      #1;
    end
    if (!hold) begin cmd_valid = 0; c8_valid = 0; end
    if (c0 < 0) begin chk_cnt++; $display("FAIL accept: cmd_ready never high within 400 cycles"); end
  endtask
  task automatic wait_rsp(input bit s, output int c, output logic [31:0] d, output logic t, output logic q);
    c = -1; d = 'x; t = 'x; q = 'x;
    for (int i = 0; i < 400 && c < 0; i++) begin
      @(negedge iClk);
      if (s ? rsp8_valid : rsp_valid) begin
        c = cyc;
        d = s ? rsp8_rdata : rsp_rdata;
        t = s ? rsp8_timeout : rsp_timeout;
        q = s ? req8 : master_req;
      end
    end
    @(posedge iClk);
    #1;
    if (c < 0) begin chk_cnt++; $display("FAIL rsp_wait: no rsp_valid within 400 cycles"); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0, c, r0, prev;
    logic [31:0] d;
    logic t, q;
    bit op;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_ready8", ready8, 0);
    chk("rst_req8", req8, 0);
    iRst = 0;
    r0 = cyc;
    send(0, 1, 32'hA5A5_0001, 0, c0);
    chk("early_accept_cycle", c0 - r0, 0);
    wait_rsp(0, c, d, t, q);
    chk("early_no_timeout", t, 0);
    chk("early_held_through_init", c - c0 > 40, 1);
    send(0, 1, 32'hDEADBEEF, 0, c0);
    wait_rsp(0, c, d, t, q);
    chk("wr_latency", c - c0, 3);
    chk("wr_timeout", t, 0);
    chk("wr_rdata", d, 0);
    send(0, 0, 32'h0, 0, c0);
    wait_rsp(0, c, d, t, q);
    chk("rd_latency", c - c0, 4);
    chk("rd_rdata", d, 32'hDEADBEEF);
    for (int k = 0; k < 6; k++) begin
      send(0, k % 2 == 0, $urandom, k < 5, c0);
      if (k > 0) chk("accept_gap", c0 - prev, op ? 4 : 5);
      prev = c0;
      op = k % 2 == 0;
    end
    wait_rsp(0, c, d, t, q);
    slave_rand = 1;
    for (int k = 0; k < 40; k++) begin
      send(0, $urandom_range(0, 1), $urandom, 0, c0);
      wait_rsp(0, c, d, t, q);
      repeat ($urandom_range(0, 3)) @(posedge iClk);
      #1;
    end
    slave_rand = 0;
    iRst = 1;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 0;
    for (int k = 0; k < 5; k++) begin
      send(0, k < 3, 32'h100 + k, 0, c0);
      wait_rsp(0, c, d, t, q);
    end
    slave_mute = 1;
    send(0, 0, 32'h0, 0, c0);
    wait_rsp(0, c, d, t, q);
    slave_mute = 0;
    chk("to_latency", c - c0, PT + 2);
    chk("to_flag", t, 1);
    chk("to_rdata", d, 0);
    chk("to_req_low", q, 0);
    @(negedge iClk);
    chk("stats_wr3", s_wr, STATS ? 3 : 0);
    chk("stats_rd2", s_rd, STATS ? 2 : 0);
    chk("stats_to1", s_to, STATS ? 1 : 0);
    @(posedge iClk);
    #1;
    send(0, 1, 32'h5555_AAAA, 0, c0);
    for (int i = 0; i < 10 && !master_ack; i++) begin
      @(posedge iClk);
      #1;
    end
    iRst = 1;
    @(posedge iClk);
    #1;
    @(negedge iClk);
    chk("midrst_req", master_req, 0);
    chk("midrst_rsp", rsp_valid, 0);
    chk("midrst_wdata", master_wdata, 0);
    @(posedge iClk);
    #1;
    iRst = 0;
    @(negedge iClk);
    chk("midrst_ready_after", cmd_ready, 1);
    @(posedge iClk);
    #1;
    send(1, 0, 32'h0, 0, c0);
    wait_rsp(1, c, d, t, q);
    chk("t8_latency", c - c0, 10);
    chk("t8_flag", t, 1);
    chk("t8_rdata", d, 0);
    chk("t8_req_low", q, 0);
    repeat (2) @(posedge iClk);
    #1;
    ack8 = 1;
    @(posedge iClk);
    #1;
    ack8 = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge iClk);
      chk("late_ack_no_rsp", {rsp8_valid, req8, ready8}, 3'b001);
    end
    @(posedge iClk);
    #1;
    send(1, 1, 32'hCAFE_0008, 0, c0);
    repeat (8) @(posedge iClk);
    #1;
    ack8 = 1;
    @(posedge iClk);
    #1;
    ack8 = 0;
    wait_rsp(1, c, d, t, q);
    chk("ackwin_wr_latency", c - c0, 10);
    chk("ackwin_wr_flag", t, 0);
    rd8 = 32'h1234_5678;
    send(1, 0, 32'h0, 0, c0);
    repeat (8) @(posedge iClk);
    #1;
    ack8 = 1;
    @(posedge iClk);
    #1;
    ack8 = 0;
    wait_rsp(1, c, d, t, q);
    chk("ackwin_rd_latency", c - c0, 11);
    chk("ackwin_rd_flag", t, 0);
    chk("ackwin_rd_rdata", d, 32'h1234_5678);
    @(negedge iClk);
    chk("stats8", {s8_rd, s8_wr}, STATS ? {16'd1, 16'd1} : 32'd0);
    chk("stats8_to", s8_to, STATS ? 1 : 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
